// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling swap sequencer driving a single-port 256x8 S-memory.
// Optional macro KSA_INIT_PASS_EN adds a leading identity-fill pass (s[n] = n).
module ksa_swap_fsm #(
    parameter int KEY_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_LEN-1:0]   key,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_wren,
    input  logic [7:0]             mem_rdata,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_RD_I, S_LAT_I, S_RD_J, S_LAT_J, S_WR_I, S_WR_J, S_DONE
    } state_t;

    state_t                 state_q;
    logic [7:0]             i_q, j_q, si_q;
    logic [2:0]             k_q;
    logic [8*KEY_LEN-1:0]   key_q;
    logic [7:0]             mem_addr_q, mem_wdata_q;
    logic                   mem_wren_q, busy_q, done_q;
    logic [7:0]             j_d, i_d;
    logic [2:0]             k_d;

    // Key byte 0 is the most significant byte of the key word.
    function automatic logic [7:0] key_byte(input logic [8*KEY_LEN-1:0] kv,
                                            input logic [2:0] idx);
        key_byte = 8'h00;
        for (int b = 0; b < KEY_LEN; b++) begin
            if (idx == 3'(b)) key_byte = kv[8*(KEY_LEN-1-b) +: 8];
        end
    endfunction

    // Next-value arithmetic for the loop counters and the j accumulator.
    always_comb begin
        j_d = j_q + mem_rdata + key_byte(key_q, k_q);
        i_d = i_q + 8'd1;
        k_d = (k_q == 3'(KEY_LEN-1)) ? 3'd0 : k_q + 3'd1;
    end

    // Sequencer: memory controls are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 3'd0;
            si_q        <= 8'd0;
            key_q       <= '0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 8'd0;
            mem_wren_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_wren_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    mem_addr_q  <= 8'd0;
                    mem_wdata_q <= 8'd0;
                    if (start) begin
                        key_q  <= key;
                        i_q    <= 8'd0;
                        j_q    <= 8'd0;
                        k_q    <= 3'd0;
                        busy_q <= 1'b1;
`ifdef KSA_INIT_PASS_EN
                        state_q    <= S_INIT;
                        mem_wren_q <= 1'b1;
`else
                        state_q    <= S_RD_I;
`endif
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
`ifdef KSA_INIT_PASS_EN
                S_INIT: begin
                    i_q <= i_d;
                    if (i_q == 8'hFF) begin
                        state_q     <= S_RD_I;
                        mem_addr_q  <= 8'd0;
                        mem_wdata_q <= 8'd0;
                    end else begin
                        mem_addr_q  <= i_d;
                        mem_wdata_q <= i_d;
                        mem_wren_q  <= 1'b1;
                    end
                end
`endif
                S_RD_I:  state_q <= S_LAT_I;
                S_LAT_I: begin
                    si_q       <= mem_rdata;
                    j_q        <= j_d;
                    mem_addr_q <= j_d;
                    state_q    <= S_RD_J;
                end
                S_RD_J:  state_q <= S_LAT_J;
                S_LAT_J: begin
                    mem_addr_q  <= i_q;
                    mem_wdata_q <= mem_rdata;
                    mem_wren_q  <= 1'b1;
                    state_q     <= S_WR_I;
                end
                S_WR_I: begin
                    mem_addr_q  <= j_q;
                    mem_wdata_q <= si_q;
                    mem_wren_q  <= 1'b1;
                    state_q     <= S_WR_J;
                end
                S_WR_J: begin
                    i_q         <= i_d;
                    k_q         <= k_d;
                    mem_wdata_q <= 8'd0;
                    if (i_q == 8'hFF) begin
                        state_q    <= S_DONE;
                        mem_addr_q <= 8'd0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q    <= S_RD_I;
                        mem_addr_q <= i_d;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    mem_addr_q  <= 8'd0;
                    mem_wdata_q <= 8'd0;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    mem_addr_q  <= 8'd0;
                    mem_wdata_q <= 8'd0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Self-checking bench for ksa_swap_fsm: synchronous-read memory model plus a software KSA reference.
module tb_ksa_swap_fsm;

    localparam int KL = 3;
`ifdef KSA_INIT_PASS_EN
    localparam int         INIT_CYC = 256;
    localparam logic [1:0] PRELOAD  = 2'd2;
`else
    localparam int         INIT_CYC = 0;
    localparam logic [1:0] PRELOAD  = 2'd1;
`endif
    localparam int DONE_EDGES = INIT_CYC + 1536;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [23:0] key;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        mem_wren, busy, done;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [256];
    logic [7:0]  exp_mem [256];
    logic [1:0]  fill_mode = 2'd0;
    logic [15:0] wlog [$];
    logic [15:0] exp_log [$];

    always #5 clk = ~clk;

    ksa_swap_fsm #(.KEY_LEN(KL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    // Single-port S-memory: write on the edge, registered read data
    always @(posedge clk) begin
        if (fill_mode == 2'd1) begin
            for (int x = 0; x < 256; x++) mem[x] <= 8'(x);
        end else if (fill_mode == 2'd2) begin
            for (int x = 0; x < 256; x++) mem[x] <= 8'hAA;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Software KSA from identity, producing final array and the ordered write list
    task automatic model(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] kb [KL];
        logic [7:0] t;
        int j;
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        exp_log.delete();
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s[i]) + int'(kb[i % KL])) % 256;
            exp_log.push_back({8'(i), s[j]});
            exp_log.push_back({8'(j), s[i]});
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int x = 0; x < 256; x++) exp_mem[x] = s[x];
    endtask

    task automatic fill(input logic [1:0] mode);
        @(negedge clk) fill_mode = mode;
        @(negedge clk) fill_mode = 2'd0;
    endtask

    task automatic cmp_mem(input string tag);
        int bad = 0;
        for (int x = 0; x < 256; x++) if (mem[x] !== exp_mem[x]) bad++;
        chk(tag, bad, 0);
    endtask

    // One full run; optional stray start pulses at cycles xs1/xs2 of the run
    task automatic run(input logic [23:0] k, input int xs1, input int xs2, input string tag);
        int done_at = -1;
        int ndone = 0;
        int bad = 0;
        model(k);
        fill(PRELOAD);
        wlog.delete();
        @(negedge clk) begin start = 1'b1; key = k; end
        @(posedge clk); #1;
        start = 1'b0;
        key = ~k;
        for (int c = 0; c < DONE_EDGES + 6; c++) begin
            if (c == 0) chk({tag, "_busy_first"}, busy, 1);
            if (c >= INIT_CYC && mem_wren) wlog.push_back({mem_addr, mem_wdata});
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            start = (c == xs1) || (c == xs2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, "_done_at"}, done_at, DONE_EDGES);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_nwrites"}, wlog.size(), exp_log.size());
        for (int x = 0; x < exp_log.size(); x++) if (wlog[x] !== exp_log[x]) bad++;
        chk({tag, "_write_seq"}, bad, 0);
        cmp_mem({tag, "_final_mem"});
    endtask

    initial begin
        logic [15:0] w;
        logic [23:0] rk;
        int nd, first, second;
        rst_n = 1'b0; start = 1'b0; key = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Directed key: first two iterations known by hand
        run(24'h000249, -1, -1, "t1");
        w = wlog[0]; chk("t1_w0", w, 16'h0000);
        w = wlog[1]; chk("t1_w1", w, 16'h0000);
        w = wlog[2]; chk("t1_w2", w, 16'h0103);
        w = wlog[3]; chk("t1_w3", w, 16'h0301);

        // All-FF key behaves as a single repeated 0xFF byte
        run(24'hFFFFFF, -1, -1, "t2");
        w = wlog[0]; chk("t2_w0", w, 16'h00FF);
        w = wlog[1]; chk("t2_w1", w, 16'hFF00);

        run(24'h000249, 10, 700, "t3");

        repeat (2) begin
            rk = 24'($urandom);
            run(rk, -1, -1, "rnd");
        end

        // Async reset in iteration 100, WR_I
        fill(PRELOAD);
        @(negedge clk) begin start = 1'b1; key = 24'h000249; end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (INIT_CYC + 604) @(posedge clk);
        #1;
        chk("t4_wren_pre", mem_wren, 1);
        chk("t4_addr_pre", mem_addr, 100);
        rst_n = 1'b0;
        #1;
        chk("t4_wren_rst", mem_wren, 0);
        chk("t4_busy_rst", busy, 0);
        chk("t4_done_rst", done, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_wren", mem_wren, 0);
        run(24'h000249, -1, -1, "t4_rerun");

        // start held high: relaunch right after DONE
        model(24'h000249);
        fill(PRELOAD);
        @(negedge clk) begin start = 1'b1; key = 24'h000249; end
        @(posedge clk); #1;
        nd = 0; first = -1; second = -1;
        for (int c = 0; c <= 2 * DONE_EDGES + 5; c++) begin
            if (done) begin
                nd++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (c == DONE_EDGES) cmp_mem("t5_mem_first");
            if (c == DONE_EDGES + 1) chk("t5_busy_idle", busy, 0);
            if (c == DONE_EDGES + 2) chk("t5_busy_relaunch", busy, 1);
            if (c == DONE_EDGES + 4) start = 1'b0;
            @(posedge clk); #1;
        end
        chk("t5_first_done", first, DONE_EDGES);
        chk("t5_second_done", second, 2 * DONE_EDGES + 2);
        chk("t5_done_count", nd, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
